// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan_ctrl
// Brief    : 4x4 matrix keypad scanner with press/release debounce and a
//            single key-code strobe per physical keypress.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scan_ctrl #(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] fila,
    output logic [3:0] columna,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       busy
);

    localparam int c_dw = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_cw = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [c_dw-1:0] c_dwell_last = c_dw'(SCAN_DIV - 1);
    localparam logic [c_cw-1:0] c_cnt_last   = c_cw'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cw-1:0] c_cnt_one    = c_cw'(1);

    localparam logic [1:0] c_scan  = 2'd0;
    localparam logic [1:0] c_deb_p = 2'd1;
    localparam logic [1:0] c_hold  = 2'd2;
    localparam logic [1:0] c_deb_r = 2'd3;

    logic [1:0]      r_state;
    logic [3:0]      r_fila_m;
    logic [3:0]      r_fila_s;
    logic [c_dw-1:0] r_dwell;
    logic [c_cw-1:0] r_cnt;
    logic [1:0]      r_row;
    logic [1:0]      r_col;
    logic [3:0]      r_columna;
    logic [3:0]      r_key_code;
    logic            r_key_valid;

    logic [1:0]      w_prio_row;
    logic [1:0]      w_col_idx;
    logic [3:0]      w_col_next;
    logic            w_row_hit;

    // Row 0 wins when several rows of the scanned column are active.
    always_comb begin
        w_prio_row = 2'd0;
        if (r_fila_s[0])      w_prio_row = 2'd0;
        else if (r_fila_s[1]) w_prio_row = 2'd1;
        else if (r_fila_s[2]) w_prio_row = 2'd2;
        else if (r_fila_s[3]) w_prio_row = 2'd3;
    end

    always_comb begin
        w_col_idx = 2'd0;
        case (r_columna)
            4'b0010: w_col_idx = 2'd1;
            4'b0100: w_col_idx = 2'd2;
            4'b1000: w_col_idx = 2'd3;
            default: w_col_idx = 2'd0;
        endcase
    end

    assign w_col_next = {r_columna[2:0], r_columna[3]};
    assign w_row_hit  = r_fila_s[r_row];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_scan;
            r_fila_m    <= 4'h0;
            r_fila_s    <= 4'h0;
            r_dwell     <= '0;
            r_cnt       <= '0;
            r_row       <= 2'd0;
            r_col       <= 2'd0;
            r_columna   <= 4'b0001;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
        end else begin
            r_fila_m    <= fila;
            r_fila_s    <= r_fila_m;
            r_key_valid <= 1'b0;
            case (r_state)
                c_scan: begin
                    if (r_dwell == c_dwell_last) begin
                        r_dwell <= '0;
                        if (|r_fila_s) begin
                            r_row   <= w_prio_row;
                            r_col   <= w_col_idx;
                            r_cnt   <= '0;
                            r_state <= c_deb_p;
                        end else begin
                            r_columna <= w_col_next;
                        end
                    end else begin
                        r_dwell <= r_dwell + 1'b1;
                    end
                end
                c_deb_p: begin
                    if (w_row_hit) begin
                        if (r_cnt == c_cnt_last) begin
                            r_key_valid <= 1'b1;
                            r_key_code  <= {r_row, r_col};
                            r_cnt       <= '0;
                            r_state     <= c_hold;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt     <= '0;
                        r_dwell   <= '0;
                        r_columna <= w_col_next;
                        r_state   <= c_scan;
                    end
                end
                c_hold: begin
                    // The first low sample already counts toward release.
                    if (!w_row_hit) begin
                        r_cnt   <= c_cnt_one;
                        r_state <= c_deb_r;
                    end
                end
                c_deb_r: begin
                    if (w_row_hit) begin
                        r_cnt   <= '0;
                        r_state <= c_hold;
                    end else if (r_cnt == c_cnt_last) begin
                        r_cnt     <= '0;
                        r_dwell   <= '0;
                        r_columna <= w_col_next;
                        r_state   <= c_scan;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= c_scan;
            endcase
        end
    end

    assign columna   = r_columna;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign busy      = (r_state != c_scan);

endmodule
`default_nettype wire
